// File: rtl/lcd_bus_receiver_pkg.sv
// Shared types and HD44780 command decoding for the LCD bus receiver.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_MODE8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } rx_state_e;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] ENTRY_MASK       = 8'hFC;
    localparam logic [7:0] ENTRY_VAL        = 8'h04;
    localparam int         SETADDR_BIT      = 7;
    localparam logic [3:0] FSET_4BIT_NIBBLE = 4'h2;

    typedef struct packed {
        logic [6:0] addr;
        logic       inc;
    } addr_state_t;

    // Panel address-counter update for one accepted byte; 7-bit arithmetic wraps mod 128.
    function automatic addr_state_t next_addr(addr_state_t cur, logic [7:0] b, logic is_data);
        addr_state_t nxt;
        nxt = cur;
        if (is_data) begin
            nxt.addr = cur.inc ? cur.addr + 7'd1 : cur.addr - 7'd1;
        end else if (b == CMD_CLEAR) begin
            nxt.addr = 7'h00;
            nxt.inc  = 1'b1;
        end else if ((b & 8'hFE) == CMD_HOME) begin
            nxt.addr = 7'h00;
        end else if ((b & ENTRY_MASK) == ENTRY_VAL) begin
            nxt.inc = b[1];
        end else if (b[SETADDR_BIT]) begin
            nxt.addr = b[6:0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// Bus-side and monitor-side signals of the LCD bus receiver.
interface lcd_bus_receiver_if;
    import lcd_pkg::*;

    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] data;

    // byte_valid and pair_err are single-cycle pulses with no back-pressure:
    // a consumer must sample byte_out/byte_is_data in the cycle byte_valid is high.
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_is_data;
    logic       four_bit_mode;
    logic [6:0] ddram_addr;
    logic       pair_err;
    rx_state_e  state_dbg;

    modport master (
        output lcd_rs, lcd_rw, lcd_e, data,
        input  byte_valid, byte_out, byte_is_data, four_bit_mode, ddram_addr, pair_err, state_dbg
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_e, data,
        output byte_valid, byte_out, byte_is_data, four_bit_mode, ddram_addr, pair_err, state_dbg
    );

endinterface

// File: rtl/lcd_strobe_detect.sv
// Synchronizes the LCD bus and reports qualified E falling edges with the sampled bus.
module lcd_strobe_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int E_MIN_HIGH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic       e_i,
    input  logic [3:0] data_i,
    output logic       strobe_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [3:0] data_o
);

    localparam int CW = $clog2(E_MIN_HIGH + 1);
    localparam logic [CW-1:0] E_MAX = CW'(E_MIN_HIGH);

    // Bit order: {e, rw, rs, data[3:0]}
    logic [6:0]    sync_q [SYNC_STAGES];
    logic [CW-1:0] cnt_q;
    logic          e_prev_q;
    logic          strobe_q;
    logic          rs_q;
    logic          rw_q;
    logic [3:0]    data_q;
    logic [6:0]    s_bus;
    logic          e_s;

    assign s_bus = sync_q[SYNC_STAGES-1];
    assign e_s   = s_bus[6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            cnt_q    <= '0;
            e_prev_q <= 1'b0;
            strobe_q <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= 4'h0;
        end else begin
            sync_q[0] <= {e_i, rw_i, rs_i, data_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

            if (e_s) begin
                if (cnt_q != E_MAX) cnt_q <= cnt_q + 1'b1;
                rw_q   <= s_bus[5];
                rs_q   <= s_bus[4];
                data_q <= s_bus[3:0];
            end else begin
                cnt_q <= '0;
            end

            e_prev_q <= e_s;
            // cnt_q still holds the completed high time in the falling-edge cycle.
            strobe_q <= e_prev_q && !e_s && (cnt_q == E_MAX);
        end
    end

    assign strobe_o = strobe_q;
    assign rs_o     = rs_q;
    assign rw_o     = rw_q;
    assign data_o   = data_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Reassembles HD44780 4-bit bus traffic into bytes and tracks the panel DDRAM address.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int E_MIN_HIGH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    lcd_bus_receiver_if.slave  bus
);

    logic        strobe;
    logic        s_rs;
    logic        s_rw;
    logic [3:0]  s_data;

    rx_state_e   state_q;
    logic        byte_valid_q;
    logic [7:0]  byte_out_q;
    logic        byte_is_data_q;
    logic        four_bit_q;
    logic        pair_err_q;
    logic [3:0]  hi_q;
    logic        hi_rs_q;
    addr_state_t as_q;
    addr_state_t as_mode8_d;
    addr_state_t as_lo_d;

    lcd_strobe_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .E_MIN_HIGH  (E_MIN_HIGH)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .rs_i     (bus.lcd_rs),
        .rw_i     (bus.lcd_rw),
        .e_i      (bus.lcd_e),
        .data_i   (bus.data),
        .strobe_o (strobe),
        .rs_o     (s_rs),
        .rw_o     (s_rw),
        .data_o   (s_data)
    );

    always_comb begin
        as_mode8_d = next_addr(as_q, {s_data, 4'h0}, 1'b0);
        as_lo_d    = next_addr(as_q, {hi_q, s_data}, hi_rs_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_MODE8;
            byte_valid_q   <= 1'b0;
            byte_out_q     <= 8'h00;
            byte_is_data_q <= 1'b0;
            four_bit_q     <= 1'b0;
            pair_err_q     <= 1'b0;
            hi_q           <= 4'h0;
            hi_rs_q        <= 1'b0;
            as_q           <= '{addr: 7'h00, inc: 1'b1};
        end else begin
            byte_valid_q <= 1'b0;
            pair_err_q   <= 1'b0;
            // Read strobes never touch the receiver state.
            if (strobe && !s_rw) begin
                case (state_q)
                    ST_MODE8: begin
                        byte_out_q     <= {s_data, 4'h0};
                        byte_is_data_q <= 1'b0;
                        byte_valid_q   <= 1'b1;
                        as_q           <= as_mode8_d;
                        if (s_data == FSET_4BIT_NIBBLE) begin
                            four_bit_q <= 1'b1;
                            state_q    <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        hi_q    <= s_data;
                        hi_rs_q <= s_rs;
                        state_q <= ST_LO;
                    end
                    ST_LO: begin
                        state_q <= ST_HI;
                        if (s_rs != hi_rs_q) begin
                            pair_err_q <= 1'b1;
                        end else begin
                            byte_out_q     <= {hi_q, s_data};
                            byte_is_data_q <= hi_rs_q;
                            byte_valid_q   <= 1'b1;
                            as_q           <= as_lo_d;
                        end
                    end
                    default: state_q <= ST_MODE8;
                endcase
            end
        end
    end

    assign bus.byte_valid    = byte_valid_q;
    assign bus.byte_out      = byte_out_q;
    assign bus.byte_is_data  = byte_is_data_q;
    assign bus.four_bit_mode = four_bit_q;
    assign bus.ddram_addr    = as_q.addr;
    assign bus.pair_err      = pair_err_q;
    assign bus.state_dbg     = state_q;

endmodule
